alarm_chime: RTL and testbench
==============================

ALARM_CHIME -- requirements
Module: alarm_chime

Interface
REQ-001 Parameter TICK_DIV, default 1000, clock cycles per chime tick (>=2).
REQ-002 Parameter ON_TICKS, default 5, buzzer-on duration per beep, in ticks.
REQ-003 Parameter OFF_TICKS, default 5, buzzer-off gap between beeps, in ticks.
REQ-004 Parameter BURST_BEEPS, default 6, beeps per burst (>=1).
REQ-005 Parameter QUIET_TICKS, default 60, silent gap between bursts, in ticks.
REQ-006 Parameter DEB_CYC, default 4, debounce qualification length, in cycles.
REQ-007 clk  input  1  single clock; all state changes on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 alarm_i  input  1  raw Alarm level from the seatbelt-warning logic, asynchronous to clk.
REQ-010 ack_i  input  1  driver mute request, single-cycle pulse, synchronous to clk.
REQ-011 buzzer_o  output  1  registered buzzer drive.
REQ-012 lamp_o  output  1  registered warning-lamp drive.
REQ-013 burst_cnt_o  output  4  bursts started since alarm qualified, saturating at 15.

Function
REQ-014 alarm_i shall pass a 2-flop synchroniser, then a debouncer: alarm_q changes only after DEB_CYC consecutive synchronised samples at the new level.
REQ-015 Tick generator shall pulse one cycle every TICK_DIV cycles and restart from 0 on every FSM state entry, so a D-tick state lasts exactly D*TICK_DIV cycles.
REQ-016 FSM states: IDLE, BEEP_ON, BEEP_OFF, QUIET, MUTED.
REQ-017 IDLE -> BEEP_ON when alarm_q=1; beep counter cleared, burst_cnt_o incremented.
REQ-018 BEEP_ON -> BEEP_OFF after ON_TICKS; beep counter incremented on exit.
REQ-019 BEEP_OFF -> QUIET after OFF_TICKS if beep counter = BURST_BEEPS, else -> BEEP_ON.
REQ-020 QUIET -> BEEP_ON after QUIET_TICKS; beep counter cleared, burst_cnt_o incremented (saturating).
REQ-021 ack_i=1 in BEEP_ON, BEEP_OFF or QUIET -> MUTED; ignored in IDLE and MUTED.
REQ-022 alarm_q=0 in any non-IDLE state -> IDLE; this takes priority over ack_i and tick events in the same cycle.
REQ-023 buzzer_o=1 only while FSM is in BEEP_ON; lamp_o=1 in every state except IDLE.
REQ-024 burst_cnt_o shall be cleared on entry to IDLE.
REQ-025 With alarm_i held high from first sampling edge N, buzzer_o shall first be 1 in cycle N+DEB_CYC+3.

Reset
REQ-026 rst_n low shall immediately force FSM=IDLE, buzzer_o=0, lamp_o=0, burst_cnt_o=0, synchroniser/debouncer/counters to 0, including mid-beep.
REQ-027 After rst_n release, alarm_i already high shall be treated as a new rising alarm (full REQ-025 latency).

Configuration
REQ-028 Macro CHIME_ESCALATE_EN defined: when BEEP_OFF completes a burst and burst_cnt_o >= 3, FSM shall go to BEEP_ON (new burst, counters updated as REQ-020) instead of QUIET, i.e. continuous beeping until ack or alarm clear.
REQ-029 Macro undefined: QUIET shall always follow a completed burst; no escalation logic present.

Structure
REQ-030 Package alarm_chime_pkg shall hold the FSM state typedef and default parameter constants.
REQ-031 Sub-module chime_tick_gen shall implement the restartable tick prescaler; synchroniser, debouncer and FSM stay in alarm_chime.

Verification (TICK_DIV=4, ON_TICKS=2, OFF_TICKS=2, BURST_BEEPS=3, QUIET_TICKS=5, DEB_CYC=2)
REQ-032 alarm_i high held -> buzzer_o high 5 cycles after first sample, 8 on/8 off x3, 20-cycle quiet, burst_cnt_o=2 at second burst start.
REQ-033 alarm_i high 1 cycle only -> buzzer_o, lamp_o stay 0, burst_cnt_o stays 0.
REQ-034 ack_i pulse mid-BEEP_ON -> buzzer_o 0 next cycle, lamp_o stays 1; alarm_i low -> lamp_o 0 after 5 cycles.
REQ-035 alarm_q fall coincident with ack_i -> FSM IDLE (not MUTED), burst_cnt_o=0.
REQ-036 rst_n pulsed low during BEEP_ON -> buzzer_o, lamp_o, burst_cnt_o 0 without clock edge; alarm held high -> restart per REQ-025.
REQ-037 CHIME_ESCALATE_EN defined, alarm held -> no quiet gap after 3rd burst; undefined -> 20-cycle quiet after every burst.

Source files
------------

// File: rtl/alarm_chime_pkg.sv
// alarm_chime_pkg -- shared types and defaults for the seatbelt alarm chime.
//   state_t       : chime FSM state encoding (also exported for debug)
//   DEF_*         : default parameter values for alarm_chime / chime_tick_gen
//   BURST_MAX     : saturation value of the 4-bit burst counter
//   sat_inc4()    : saturating increment for the burst counter
package alarm_chime_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEEP_ON,
    ST_BEEP_OFF,
    ST_QUIET,
    ST_MUTED
  } state_t;

  localparam int DEF_TICK_DIV    = 1000;
  localparam int DEF_ON_TICKS    = 5;
  localparam int DEF_OFF_TICKS   = 5;
  localparam int DEF_BURST_BEEPS = 6;
  localparam int DEF_QUIET_TICKS = 60;
  localparam int DEF_DEB_CYC     = 4;

  localparam logic [3:0] BURST_MAX = 4'd15;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == BURST_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/alarm_chime_if.sv
// alarm_chime_if -- signal bundle between the warning logic / driver controls
// and the chime block.
//   alarm_i     : raw alarm level, asynchronous to clk
//   ack_i       : driver mute request
//   buzzer_o    : registered buzzer drive
//   lamp_o      : registered warning-lamp drive
//   burst_cnt_o : bursts started since the alarm qualified (saturates at 15)
//   dbg_state   : current chime FSM state, for observation only
// Handshake: there is no valid/ready pair; ack_i is a one-cycle request
// sampled on the rising edge of clk and acted on only while the chime sounds
// (BEEP_ON, BEEP_OFF, QUIET); there is no acknowledge back to the requester.
interface alarm_chime_if;
  import alarm_chime_pkg::*;

  logic       alarm_i;
  logic       ack_i;
  logic       buzzer_o;
  logic       lamp_o;
  logic [3:0] burst_cnt_o;
  state_t     dbg_state;

  modport master (
    output alarm_i, ack_i,
    input  buzzer_o, lamp_o, burst_cnt_o, dbg_state
  );

  modport slave (
    input  alarm_i, ack_i,
    output buzzer_o, lamp_o, burst_cnt_o, dbg_state
  );
endinterface

// File: rtl/alarm_chime_tick_gen.sv
// chime_tick_gen -- restartable tick prescaler.
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : high during the first cycle of a new FSM state
//   tick       : one-cycle pulse every TICK_DIV cycles counted from restart
// The restart cycle itself counts as phase 0, so the first tick after a
// restart lands exactly TICK_DIV cycles after the state entry.
module chime_tick_gen
  import alarm_chime_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= CW'(1);
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !restart && (cnt == LAST);
endmodule

// File: rtl/alarm_chime.sv
// alarm_chime -- seatbelt warning chime controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alarm_chime_if.slave (alarm_i, ack_i in; buzzer_o, lamp_o,
//                burst_cnt_o, dbg_state out)
// alarm_i is synchronised and debounced into alarm_q, which drives a
// beep/burst FSM timed in ticks from chime_tick_gen.
// Build option: define CHIME_ESCALATE_EN to keep beeping without the quiet
// gap once three or more bursts have been started.
module alarm_chime
  import alarm_chime_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int ON_TICKS    = DEF_ON_TICKS,
  parameter int OFF_TICKS   = DEF_OFF_TICKS,
  parameter int BURST_BEEPS = DEF_BURST_BEEPS,
  parameter int QUIET_TICKS = DEF_QUIET_TICKS,
  parameter int DEB_CYC     = DEF_DEB_CYC
) (
  input  logic         clk,
  input  logic         rst_n,
  alarm_chime_if.slave bus
);
`ifdef CHIME_ESCALATE_EN
  localparam logic [3:0] ESC_BURSTS = 4'd3;
`endif

  logic        sync1, sync2, alarm_q;
  logic [7:0]  deb_cnt;
  state_t      state;
  logic        restart, tick;
  logic [15:0] tick_cnt;
  logic [7:0]  beep_cnt;
  logic        buzzer_r, lamp_r;
  logic [3:0]  burst_r;
  logic        on_done, off_done, quiet_done, burst_done;

  // Synchroniser and debouncer. deb_cnt counts synchronised samples that
  // disagree with alarm_q; once DEB_CYC have been seen, the next disagreeing
  // sample commits the new level, which yields the DEB_CYC+3 alarm latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      alarm_q <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= bus.alarm_i;
      sync2 <= sync1;
      if (sync2 == alarm_q) begin
        deb_cnt <= '0;
      end else if (deb_cnt == 8'(DEB_CYC)) begin
        alarm_q <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 8'd1;
      end
    end
  end

  chime_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  assign on_done    = tick && (tick_cnt == 16'(ON_TICKS - 1));
  assign off_done   = tick && (tick_cnt == 16'(OFF_TICKS - 1));
  assign quiet_done = tick && (tick_cnt == 16'(QUIET_TICKS - 1));
  assign burst_done = (beep_cnt == 8'(BURST_BEEPS));

  // Chime FSM. Every transition pulses restart and clears tick_cnt so each
  // state is timed from its own entry. Outputs are updated together with the
  // state so they follow the state register without an extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      restart  <= 1'b0;
      tick_cnt <= '0;
      beep_cnt <= '0;
      buzzer_r <= 1'b0;
      lamp_r   <= 1'b0;
      burst_r  <= '0;
    end else begin
      restart <= 1'b0;
      if (tick) tick_cnt <= tick_cnt + 16'd1;

      // Losing the qualified alarm wins over ack and tick events.
      if (state != ST_IDLE && !alarm_q) begin
        state    <= ST_IDLE;
        restart  <= 1'b1;
        tick_cnt <= '0;
        buzzer_r <= 1'b0;
        lamp_r   <= 1'b0;
        burst_r  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (alarm_q) begin
              state    <= ST_BEEP_ON;
              restart  <= 1'b1;
              tick_cnt <= '0;
              beep_cnt <= '0;
              buzzer_r <= 1'b1;
              lamp_r   <= 1'b1;
              burst_r  <= sat_inc4(burst_r);
            end
          end
          ST_BEEP_ON, ST_BEEP_OFF, ST_QUIET: begin
            if (bus.ack_i) begin
              state    <= ST_MUTED;
              restart  <= 1'b1;
              tick_cnt <= '0;
              buzzer_r <= 1'b0;
            end else if (state == ST_BEEP_ON && on_done) begin
              state    <= ST_BEEP_OFF;
              restart  <= 1'b1;
              tick_cnt <= '0;
              beep_cnt <= beep_cnt + 8'd1;
              buzzer_r <= 1'b0;
            end else if (state == ST_BEEP_OFF && off_done) begin
              restart  <= 1'b1;
              tick_cnt <= '0;
              if (!burst_done) begin
                state    <= ST_BEEP_ON;
                buzzer_r <= 1'b1;
`ifdef CHIME_ESCALATE_EN
              end else if (burst_r >= ESC_BURSTS) begin
                // Escalated: start the next burst straight away.
                state    <= ST_BEEP_ON;
                buzzer_r <= 1'b1;
                beep_cnt <= '0;
                burst_r  <= sat_inc4(burst_r);
`endif
              end else begin
                state <= ST_QUIET;
              end
            end else if (state == ST_QUIET && quiet_done) begin
              state    <= ST_BEEP_ON;
              restart  <= 1'b1;
              tick_cnt <= '0;
              beep_cnt <= '0;
              buzzer_r <= 1'b1;
              burst_r  <= sat_inc4(burst_r);
            end
          end
          ST_MUTED: begin
            // Held silent with the lamp on until the alarm clears.
          end
          default: begin
            state    <= ST_IDLE;
            restart  <= 1'b1;
            tick_cnt <= '0;
            buzzer_r <= 1'b0;
            lamp_r   <= 1'b0;
            burst_r  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.buzzer_o    = buzzer_r;
  assign bus.lamp_o      = lamp_r;
  assign bus.burst_cnt_o = burst_r;
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_alarm_chime.sv
// tb_alarm_chime -- self-checking bench for alarm_chime with a cycle-timed
// behavioural model (durations in cycles, debounce as a sample window).
module tb_alarm_chime;
  import alarm_chime_pkg::*;

  localparam int TD    = 4;
  localparam int ON    = 2;
  localparam int OFF   = 2;
  localparam int BB    = 3;
  localparam int QT    = 5;
  localparam int DEB   = 2;
  localparam int LIMIT = 300;
`ifdef CHIME_ESCALATE_EN
  localparam bit ESC = 1'b1;
`else
  localparam bit ESC = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alarm_chime_if bus();

  alarm_chime #(
    .TICK_DIV(TD), .ON_TICKS(ON), .OFF_TICKS(OFF), .BURST_BEEPS(BB),
    .QUIET_TICKS(QT), .DEB_CYC(DEB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  state_t m_st;
  int     m_left, m_beeps, m_bursts;
  bit     q_m;
  bit     hist[$];

  function automatic void push_exp();
    exp_q.push_back({m_st, 4'(m_bursts), m_st != ST_IDLE, m_st == ST_BEEP_ON});
  endfunction

  function automatic void enter(input state_t s, input int ticks);
    m_st   = s;
    m_left = ticks * TD;
  endfunction

  function automatic void start_burst();
    m_beeps  = 0;
    m_bursts = (m_bursts < 15) ? m_bursts + 1 : 15;
    enter(ST_BEEP_ON, ON);
  endfunction

  function automatic void model_reset();
    m_st = ST_IDLE; m_left = 0; m_beeps = 0; m_bursts = 0; q_m = 1'b0;
    hist.delete();
    for (int i = 0; i < DEB + 3; i++) hist.push_back(1'b0);
    push_exp();
  endfunction

  function automatic void fsm_step(input bit ack);
    if (m_st != ST_IDLE && !q_m) begin
      m_st = ST_IDLE;
      m_bursts = 0;
    end else if (m_st == ST_IDLE) begin
      if (q_m) start_burst();
    end else if (m_st != ST_MUTED) begin
      if (ack) m_st = ST_MUTED;
      else begin
        m_left--;
        if (m_left == 0) begin
          if (m_st == ST_BEEP_ON) begin
            m_beeps++;
            enter(ST_BEEP_OFF, OFF);
          end else if (m_st == ST_BEEP_OFF) begin
            if (m_beeps < BB) enter(ST_BEEP_ON, ON);
            else if (ESC && m_bursts >= 3) start_burst();
            else enter(ST_QUIET, QT);
          end else begin
            start_burst();
          end
        end
      end
    end
  endfunction

  function automatic void model_step(input bit a, input bit ack);
    bit flip;
    fsm_step(ack);
    // Qualified level flips once the DEB+1 samples that have crossed the
    // two-flop synchroniser all disagree with it.
    flip = 1'b1;
    for (int i = 0; i <= DEB; i++)
      if (hist[hist.size() - 2 - i] == q_m) flip = 1'b0;
    if (flip) q_m = !q_m;
    hist.push_back(a);
    if (hist.size() > DEB + 4) void'(hist.pop_front());
    push_exp();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step(bus.alarm_i, bus.ack_i);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) chk("exp_avail", 16'd0, 16'd1);
      else begin
        logic [8:0] e;
        e = exp_q[$];
        exp_q.delete();
        chk("buzzer", 16'(bus.buzzer_o), 16'(e[0]));
        chk("lamp", 16'(bus.lamp_o), 16'(e[1]));
        chk("burst_cnt", 16'(bus.burst_cnt_o), 16'(e[5:2]));
        chk("state", 16'(bus.dbg_state), 16'(e[8:6]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    bus.ack_i = 1'b1;
    @(negedge clk);
    bus.ack_i = 1'b0;
  endtask

  // Count negedges until buzzer (sel=0) or lamp (sel=1) reaches lvl.
  task automatic wait_sig(input bit sel, input logic lvl, output int n);
    logic v;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      v = sel ? bus.lamp_o : bus.buzzer_o;
    end while (v !== lvl && n < LIMIT);
  endtask

  // From a buzzer rise, walk one burst and return the silent gap after it.
  task automatic through_burst(output int gap);
    int n;
    for (int b = 0; b < BB; b++) begin
      wait_sig(1'b0, 1'b0, n);
      chk("on_len", 16'(n), 16'(ON * TD));
      if (b < BB - 1) begin
        wait_sig(1'b0, 1'b1, n);
        chk("off_len", 16'(n), 16'(OFF * TD));
      end
    end
    wait_sig(1'b0, 1'b1, gap);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, g, hold, r;
    bit seen;
    bus.alarm_i = 1'b0;
    bus.ack_i   = 1'b0;
    cycles(3);
    chk("rst_buzzer", 16'(bus.buzzer_o), 16'd0);
    chk("rst_lamp", 16'(bus.lamp_o), 16'd0);
    chk("rst_burst", 16'(bus.burst_cnt_o), 16'd0);
    chk("rst_state", 16'(bus.dbg_state), 16'(ST_IDLE));
    chk_en = 1'b1;
    rst_n  = 1'b1;
    cycles(4);

    // Held alarm: latency, beep/gap timing, burst counting.
    bus.alarm_i = 1'b1;
    wait_sig(1'b0, 1'b1, n);
    chk("latency", 16'(n - 1), 16'(DEB + 3));
    chk("burst_first", 16'(bus.burst_cnt_o), 16'd1);
    through_burst(g);
    chk("gap_b1", 16'(g), 16'(OFF * TD + QT * TD));
    chk("burst_second", 16'(bus.burst_cnt_o), 16'd2);
    through_burst(g);
    chk("gap_b2", 16'(g), 16'(OFF * TD + QT * TD));
    through_burst(g);
    chk("gap_b3", 16'(g), ESC ? 16'(OFF * TD) : 16'(OFF * TD + QT * TD));
    chk("burst_fourth", 16'(bus.burst_cnt_o), 16'd4);
    bus.alarm_i = 1'b0;
    wait_sig(1'b1, 1'b0, n);
    chk("lamp_release", 16'(n - 1), 16'(DEB + 3));
    chk("burst_clear", 16'(bus.burst_cnt_o), 16'd0);
    cycles(5);

    // One-cycle glitch must be filtered.
    bus.alarm_i = 1'b1;
    cycles(1);
    bus.alarm_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.lamp_o !== 1'b0 || bus.buzzer_o !== 1'b0) seen = 1'b1;
    end
    chk("glitch_quiet", 16'(seen), 16'd0);

    // Ack mid-beep mutes but keeps the lamp.
    bus.alarm_i = 1'b1;
    wait_sig(1'b0, 1'b1, n);
    cycles($urandom_range(1, 5));
    pulse_ack();
    chk("ack_buzzer", 16'(bus.buzzer_o), 16'd0);
    chk("ack_lamp", 16'(bus.lamp_o), 16'd1);
    chk("ack_state", 16'(bus.dbg_state), 16'(ST_MUTED));
    cycles(30);
    chk("muted_lamp", 16'(bus.lamp_o), 16'd1);
    bus.alarm_i = 1'b0;
    wait_sig(1'b1, 1'b0, n);
    chk("muted_release", 16'(n - 1), 16'(DEB + 3));
    cycles(5);

    // Alarm clear coincident with ack: clear wins.
    bus.alarm_i = 1'b1;
    wait_sig(1'b0, 1'b1, n);
    cycles($urandom_range(2, 30));
    bus.alarm_i = 1'b0;
    cycles(DEB + 3);
    pulse_ack();
    chk("coinc_state", 16'(bus.dbg_state), 16'(ST_IDLE));
    chk("coinc_burst", 16'(bus.burst_cnt_o), 16'd0);
    cycles(5);

    // Asynchronous reset in the middle of a beep.
    bus.alarm_i = 1'b1;
    wait_sig(1'b0, 1'b1, n);
    chk("pre_rst_buzzer", 16'(bus.buzzer_o), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_buzzer", 16'(bus.buzzer_o), 16'd0);
    chk("arst_lamp", 16'(bus.lamp_o), 16'd0);
    chk("arst_burst", 16'(bus.burst_cnt_o), 16'd0);
    cycles(2);
    rst_n = 1'b1;
    wait_sig(1'b0, 1'b1, n);
    chk("rst_relatency", 16'(n - 1), 16'(DEB + 3));
    cycles(20);
    bus.alarm_i = 1'b0;
    cycles(10);

    // Randomised alarm levels and ack pulses against the model.
    hold = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold == 0) begin
        r = $urandom_range(0, 3);
        bus.alarm_i = (r != 0) ? ~bus.alarm_i : bus.alarm_i;
        hold = (r == 1) ? $urandom_range(1, 3) : $urandom_range(5, 150);
      end
      hold--;
      bus.ack_i = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    bus.ack_i   = 1'b0;
    bus.alarm_i = 1'b0;
    cycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
